// File: rtl/obstacle_spawner.sv
// -----------------------------------------------------------------------------
// obstacle_spawner
//
// Pool of N obstacle slots for the road game. New obstacles are spawned from
// the pseudo-random word q when its two DROP_W-bit slices match. Every active
// obstacle moves down by STEP rows on each frame tick. Obstacles retire when
// they pass Y_MAX or when the collision logic kills them.
//
// Optional feature macro: OBSTACLE_COOLDOWN_EN
//   defined   -> after each spawn, further spawns are blocked for COOL ticks
//   undefined -> no cooldown counter is built; spawns may occur every cycle
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   on           in   game running; when low, all slots are cleared synchronously
//   q            in   random word: ra=[DROP_W-1:0], rb=[2*DROP_W-1:DROP_W],
//                     rx=[2*DROP_W +: XW]
//   upsig        in   one-cycle frame tick
//   kill         in   per-slot retire request (one cycle)
//   obstacle_on  out  slot active flags
//   obstacle_x   out  slot i x position at [i*XW +: XW]
//   obstacle_y   out  slot i y position at [i*YW +: YW]
//   spawn        out  one-cycle strobe when a slot was filled
// -----------------------------------------------------------------------------
module obstacle_spawner #(
    parameter int N      = 6,
    parameter int XW     = 8,
    parameter int YW     = 10,
    parameter int RND_W  = 19,
    parameter int DROP_W = 4,
    parameter int X_MAX  = 200,
    parameter int Y_MAX  = 479,
    parameter int STEP   = 1,
    parameter int COOL   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              on,
    input  logic [RND_W-1:0]  q,
    input  logic              upsig,
    input  logic [N-1:0]      kill,
    output logic [N-1:0]      obstacle_on,
    output logic [N*XW-1:0]   obstacle_x,
    output logic [N*YW-1:0]   obstacle_y,
    output logic              spawn
);

    localparam int USED_W = 2*DROP_W + XW;

    localparam logic [XW-1:0] X_MAX_C = XW'(X_MAX);
    localparam logic [YW:0]   Y_MAX_C = (YW+1)'(Y_MAX);
    localparam logic [YW:0]   STEP_C  = (YW+1)'(STEP);

    // Random word slices
    logic [DROP_W-1:0] ra_s;
    logic [DROP_W-1:0] rb_s;
    logic [XW-1:0]     rx_s;
    logic [XW-1:0]     rx_clamp_s;

    assign ra_s       = q[DROP_W-1:0];
    assign rb_s       = q[2*DROP_W-1:DROP_W];
    assign rx_s       = q[2*DROP_W +: XW];
    assign rx_clamp_s = (rx_s > X_MAX_C) ? X_MAX_C : rx_s;

    // Upper bits of q beyond the used slices carry no meaning here.
    if (RND_W > USED_W) begin : g_unused_q
        logic unused_q_s;
        assign unused_q_s = ^q[RND_W-1:USED_W];
    end

    // Slot state
    logic [N-1:0]    on_q, on_d;
    logic [N*XW-1:0] x_q,  x_d;
    logic [N*YW-1:0] y_q,  y_d;
    logic            spawn_q, spawn_d;

    // Free slots are sampled from the registered state, so a slot retired
    // or killed this cycle only becomes allocatable next cycle.
    logic [N-1:0] free_s;
    logic [N-1:0] grant_s;
    logic         any_free_s;
    logic         cool_zero_s;
    logic         drop_s;

    assign free_s     = ~on_q;
    // Isolate the lowest set bit: one-hot grant for the lowest free slot.
    assign grant_s    = free_s & (~free_s + N'(1));
    assign any_free_s = |free_s;
    assign drop_s     = on && (ra_s == rb_s) && cool_zero_s && any_free_s;

`ifdef OBSTACLE_COOLDOWN_EN
    localparam int CW = (COOL < 2) ? 1 : $clog2(COOL + 1);

    logic [CW-1:0] cool_q, cool_d;

    assign cool_zero_s = (cool_q == {CW{1'b0}});

    // Cooldown next state: load on spawn, count down on ticks, saturate at 0
    always_comb begin
        cool_d = cool_q;
        if (!on) begin
            cool_d = {CW{1'b0}};
        end else if (drop_s) begin
            cool_d = CW'(COOL);
        end else if (upsig && !cool_zero_s) begin
            cool_d = cool_q - CW'(1);
        end else begin
            cool_d = cool_q;
        end
    end

    // Cooldown register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cool_q <= {CW{1'b0}};
        end else begin
            cool_q <= cool_d;
        end
    end
`else
    logic [31:0] unused_cool_s;
    assign unused_cool_s = COOL;
    assign cool_zero_s   = 1'b1;
`endif

    // Per-slot y + STEP, one bit wider so passing the bottom edge is visible
    logic [YW:0] y_sum_s [N];

    for (genvar g = 0; g < N; g++) begin : g_ysum
        assign y_sum_s[g] = {1'b0, y_q[g*YW +: YW]} + STEP_C;
    end

    // Slot next state; priority per slot: clear > kill > spawn > motion
    always_comb begin
        on_d    = on_q;
        x_d     = x_q;
        y_d     = y_q;
        spawn_d = on && drop_s;
        for (int i = 0; i < N; i++) begin
            if (!on) begin
                on_d[i]           = 1'b0;
                x_d[i*XW +: XW]   = {XW{1'b0}};
                y_d[i*YW +: YW]   = {YW{1'b0}};
            end else if (kill[i] && on_q[i]) begin
                on_d[i]           = 1'b0;
            end else if (drop_s && grant_s[i]) begin
                on_d[i]           = 1'b1;
                x_d[i*XW +: XW]   = rx_clamp_s;
                y_d[i*YW +: YW]   = {YW{1'b0}};
            end else if (upsig && on_q[i]) begin
                // Retiring keeps x/y frozen at their last on-screen values.
                if (y_sum_s[i] > Y_MAX_C) begin
                    on_d[i]         = 1'b0;
                end else begin
                    y_d[i*YW +: YW] = y_sum_s[i][YW-1:0];
                end
            end else begin
                on_d[i]           = on_q[i];
            end
        end
    end

    // Slot and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_q    <= {N{1'b0}};
            x_q     <= {(N*XW){1'b0}};
            y_q     <= {(N*YW){1'b0}};
            spawn_q <= 1'b0;
        end else begin
            on_q    <= on_d;
            x_q     <= x_d;
            y_q     <= y_d;
            spawn_q <= spawn_d;
        end
    end

    assign obstacle_on = on_q;
    assign obstacle_x  = x_q;
    assign obstacle_y  = y_q;
    assign spawn       = spawn_q;

endmodule
